// File: rtl/uart_loader_if.sv
// uart_loader_if: memory-upload port between the serial loader (master) and its host side (slave).
interface uart_loader_if #(
    parameter int ROM_DEPTH = 14,
    parameter int ISA_WIDTH = 32
);
    logic                 uart_rx;
    logic                 uart_start;
    logic                 uart_write_enable;
    logic [ISA_WIDTH-1:0] uart_data;
    logic [ROM_DEPTH:0]   uart_addr;
    logic                 uart_busy;
    logic                 uart_done;
    logic                 uart_error;

    modport master (
        input  uart_rx, uart_start,
        output uart_write_enable, uart_data, uart_addr, uart_busy, uart_done, uart_error
    );

    modport slave (
        output uart_rx, uart_start,
        input  uart_write_enable, uart_data, uart_addr, uart_busy, uart_done, uart_error
    );
endinterface

// File: rtl/uart_loader.sv
// uart_loader: 8N1 UART receiver that assembles little-endian words and streams them to the memory upload port.
module uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ROM_DEPTH    = 14,
    parameter int ISA_WIDTH    = 32
) (
    input logic           clk,
    input logic           rst,
    uart_loader_if.master bus
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} st_t;

    logic [1:0]           r_sync;
    logic                 r_start_d;
    rx_t                  r_rx, w_rx_nxt;
    st_t                  r_st, w_st_nxt;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_byte_valid, r_frame_err;
    logic [1:0]           r_idx;
    logic [23:0]          r_word;
    logic [ISA_WIDTH-1:0] r_data;
    logic [ROM_DEPTH:0]   r_addr;
    logic                 w_line, w_run, w_start_edge, w_half, w_full, w_byte_set, w_err_set;

    assign w_line       = r_sync[1];
    assign w_run        = r_st == S_RECV;
    assign w_start_edge = bus.uart_start & ~r_start_d;
    assign w_half       = r_cnt == HALF;
    assign w_full       = r_cnt == FULL;

    // Flops reset high so a start held across reset does not look like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_start_d <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], bus.uart_rx};
            r_start_d <= bus.uart_start;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx <= RX_IDLE;
        else     r_rx <= w_rx_nxt;
    end

    always_comb begin
        w_rx_nxt = r_rx;
        if (!w_run) w_rx_nxt = RX_IDLE;
        else begin
            case (r_rx)
                RX_IDLE:  if (!w_line) w_rx_nxt = RX_START;
                RX_START: if (w_half) w_rx_nxt = w_line ? RX_IDLE : RX_DATA;
                RX_DATA:  if (w_full && r_bit == 3'd7) w_rx_nxt = RX_STOP;
                RX_STOP:  if (w_full) w_rx_nxt = RX_IDLE;
                default:  w_rx_nxt = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        w_byte_set = w_run && r_rx == RX_STOP && w_full && w_line;
        w_err_set  = w_run && r_rx == RX_STOP && w_full && !w_line;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_byte_set;
            r_frame_err  <= w_err_set;
            r_cnt        <= (r_rx != w_rx_nxt || w_full) ? '0 : r_cnt + CW'(1);
            if (r_rx == RX_START) r_bit <= '0;
            if (r_rx == RX_DATA && w_full) begin
                r_shift <= {w_line, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_st <= S_IDLE;
        else     r_st <= w_st_nxt;
    end

    // A start edge wins over everything, including a byte arriving in the same cycle.
    always_comb begin
        w_st_nxt = r_st;
        if (w_start_edge) w_st_nxt = S_RECV;
        else if ((r_st == S_RECV || r_st == S_WRITE) && !bus.uart_start) w_st_nxt = S_IDLE;
        else begin
            case (r_st)
                S_RECV:  w_st_nxt = r_frame_err ? S_ERR : (r_byte_valid && r_idx == 2'd3) ? S_WRITE : S_RECV;
                S_WRITE: w_st_nxt = &r_addr ? S_DONE : S_RECV;
                default: w_st_nxt = r_st;
            endcase
        end
    end

    always_comb begin
        bus.uart_write_enable = r_st == S_WRITE;
        bus.uart_busy         = r_st == S_RECV || r_st == S_WRITE;
        bus.uart_done         = r_st == S_DONE;
        bus.uart_error        = r_st == S_ERR;
    end

    assign bus.uart_data = r_data;
    assign bus.uart_addr = r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_word <= '0;
            r_data <= '0;
            r_addr <= '0;
        end else if (w_start_edge) begin
            r_idx  <= '0;
            r_addr <= '0;
        end else if (r_st == S_RECV && r_byte_valid) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_data <= {r_shift, r_word};
            else               r_word[{r_idx, 3'b000} +: 8] <= r_shift;
        end else if (r_st == S_WRITE && !(&r_addr)) begin
            r_addr <= r_addr + (ROM_DEPTH + 1)'(1);
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed session scenarios with randomized payloads checked against a word-assembly model.
module tb_uart_loader;
    localparam int CPB = 4;
    localparam int RD  = 2;
    localparam int NW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0]  bq[$];
    int          q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];
    int          done_cyc = -1;
    logic        done_d = 1'b0;

    uart_loader_if #(.ROM_DEPTH(RD), .ISA_WIDTH(32)) u_if ();

    uart_loader #(.CLKS_PER_BIT(CPB), .ROM_DEPTH(RD), .ISA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.uart_write_enable) begin
            q_addr.push_back(int'(u_if.uart_addr));
            q_data.push_back(u_if.uart_data);
            q_cyc.push_back(cyc);
        end
        if (u_if.uart_done && !done_d) done_cyc = cyc;
        done_d = u_if.uart_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        return 32'(bq[4*i]) + (32'(bq[4*i+1]) << 8) + (32'(bq[4*i+2]) << 16) + (32'(bq[4*i+3]) << 24);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop, input int idle_bits);
        u_if.uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        u_if.uart_rx = stop;
        repeat (CPB) @(negedge clk);
        u_if.uart_rx = 1'b1;
        repeat (idle_bits * CPB) @(negedge clk);
    endtask

    task automatic send_all(input int n, input bit b2b);
        for (int i = 0; i < n; i++) send_byte(bq[i], 1'b1, b2b ? 0 : int'($urandom_range(0, 2)));
        repeat (8) @(negedge clk);
    endtask

    task automatic open_session();
        u_if.uart_start = 1'b0;
        repeat (2) @(negedge clk);
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        done_cyc = -1;
        u_if.uart_start = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_random(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
    endtask

    task automatic check_words(input string tag, input int n);
        chk({tag, "_count"}, 32'(q_addr.size()), 32'(n));
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(q_addr[i]), 32'(i));
            chk({tag, "_data"}, q_data[i], word_of(i));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_we"}, 32'(u_if.uart_write_enable), 32'd0);
        chk({tag, "_data"}, u_if.uart_data, 32'd0);
        chk({tag, "_addr"}, 32'(u_if.uart_addr), 32'd0);
        chk({tag, "_busy"}, 32'(u_if.uart_busy), 32'd0);
        chk({tag, "_done"}, 32'(u_if.uart_done), 32'd0);
        chk({tag, "_error"}, 32'(u_if.uart_error), 32'd0);
    endtask

    initial begin
        u_if.uart_rx    = 1'b1;
        u_if.uart_start = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full upload of 0x00..0x1F with random idle gaps
        bq.delete();
        for (int i = 0; i < 4 * NW; i++) bq.push_back(8'(i));
        open_session();
        chk("busy_after_start", 32'(u_if.uart_busy), 32'd1);
        send_all(4 * NW, 1'b0);
        check_words("full", NW);
        if (q_data.size() == NW) begin
            chk("full_first_word", q_data[0], 32'h0302_0100);
            chk("full_word4", q_data[4], 32'h1312_1110);
            chk("full_done_timing", 32'(done_cyc), 32'(q_cyc[NW-1] + 1));
        end
        chk("full_done", 32'(u_if.uart_done), 32'd1);
        chk("full_busy", 32'(u_if.uart_busy), 32'd0);
        chk("full_error", 32'(u_if.uart_error), 32'd0);

        // Back-to-back random stream
        fill_random(4 * NW);
        open_session();
        chk("b2b_done_cleared", 32'(u_if.uart_done), 32'd0);
        send_all(4 * NW, 1'b1);
        check_words("b2b", NW);
        for (int i = 1; i < q_cyc.size(); i++) chk("b2b_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 32'd160);
        if (q_cyc.size() == NW) chk("b2b_done_timing", 32'(done_cyc), 32'(q_cyc[NW-1] + 1));
        chk("b2b_done", 32'(u_if.uart_done), 32'd1);

        // Framing error on the first byte of a word
        open_session();
        send_byte(8'hA5, 1'b0, 1);
        repeat (4) @(negedge clk);
        chk("ferr_error", 32'(u_if.uart_error), 32'd1);
        chk("ferr_done", 32'(u_if.uart_done), 32'd0);
        chk("ferr_busy", 32'(u_if.uart_busy), 32'd0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, 1);
        repeat (8) @(negedge clk);
        chk("ferr_no_strobe", 32'(q_addr.size()), 32'd0);
        open_session();
        chk("ferr_cleared", 32'(u_if.uart_error), 32'd0);
        chk("ferr_restart_busy", 32'(u_if.uart_busy), 32'd1);

        // Start-bit glitch shorter than half a bit, then a real 0x5A word
        u_if.uart_rx = 1'b0;
        @(negedge clk);
        u_if.uart_rx = 1'b1;
        repeat (10) @(negedge clk);
        fill_random(4);
        bq[0] = 8'h5A;
        send_all(4, 1'b0);
        check_words("glitch", 1);

        // Abort after two words, then restart from address 0
        fill_random(4 * 3);
        open_session();
        send_all(8, 1'b0);
        u_if.uart_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", 32'(u_if.uart_busy), 32'd0);
        chk("abort_done", 32'(u_if.uart_done), 32'd0);
        chk("abort_error", 32'(u_if.uart_error), 32'd0);
        chk("abort_count", 32'(q_addr.size()), 32'd2);
        fill_random(4);
        open_session();
        send_all(4, 1'b0);
        check_words("abort_restart", 1);

        // Async reset in the middle of the third word's first byte
        fill_random(4 * 3);
        bq[0] = 8'h81;
        open_session();
        send_all(8, 1'b0);
        u_if.uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        u_if.uart_rx = bq[8][0];
        repeat (CPB) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        u_if.uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
        for (int i = 8; i < 12; i++) send_byte(bq[i], 1'b1, 1);
        repeat (8) @(negedge clk);
        chk("rst_no_strobe", 32'(q_addr.size()), 32'd2);
        chk("rst_busy", 32'(u_if.uart_busy), 32'd0);
        fill_random(4);
        open_session();
        send_all(4, 1'b0);
        check_words("rst_restart", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
# uart_loader

Serial program loader that feeds the instruction/data memory upload port of the debug core. It deserialises 8N1 UART bytes from the host, assembles little-endian 32-bit words, and drives the memory upload interface (`uart_write_enable`, `uart_data`, `uart_addr`). It sits beside the hazard unit, which starts an upload session and holds the pipeline until `uart_done`. Address bit `ROM_DEPTH` selects the target: 0 is instruction memory, 1 is data memory.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); minimum 4.
- `ROM_DEPTH`, default 14: word-address width of each memory half.
- `ISA_WIDTH`, default 32: word width; fixed at 32 (4 bytes per word).
- `clk` input, 1 bit: single clock; all logic on posedge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `uart_rx` input, 1 bit: asynchronous serial line, idle high.
- `uart_start` input, 1 bit: level from the hazard unit; a rising edge opens a session.
- `uart_write_enable` output, 1 bit: one-cycle write strobe per assembled word.
- `uart_data` output, `ISA_WIDTH` bits: assembled word.
- `uart_addr` output, `ROM_DEPTH+1` bits: word address; the MSB selects data memory.
- `uart_busy` output, 1 bit: session in progress.
- `uart_done` output, 1 bit: session completed; level.
- `uart_error` output, 1 bit: framing error occurred in the last session; level.

## Operation
- `uart_rx` passes through a 2-flop synchroniser before any use.
- **Bit receiver FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.**
  - RX_IDLE: a low on the synchronised line starts a half-bit count.
  - RX_START: at `CLKS_PER_BIT/2`, a line still low enters RX_DATA; a line that is high is a glitch and returns to RX_IDLE.
  - RX_DATA: samples every `CLKS_PER_BIT` cycles, 8 bits, LSB first.
  - RX_STOP: one bit later, a high line gives a one-cycle `byte_valid`; a low line gives `frame_err`.
  - The receiver runs only while the session FSM is in S_RECV. In every other state it is held in RX_IDLE.
- **Session FSM: S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR.**
  - S_IDLE: a `uart_start` rising edge clears the byte index, word address, `uart_done` and `uart_error`, then enters S_RECV.
  - S_RECV: each `byte_valid` writes the byte to lane `byte_idx` of the word register (byte 0 → bits [7:0]).
    - `byte_idx` is 2 bits and wraps.
    - A valid byte with `byte_idx==3` enters S_WRITE.
  - S_WRITE: one cycle.
    - Asserts `uart_write_enable`.
    - If the address equals all-ones (`2^(ROM_DEPTH+1)-1`), the next state is S_DONE. Otherwise the address increments by 1 and the next state is S_RECV.
  - S_DONE: `uart_done`=1 and `uart_busy`=0. Stays until a new `uart_start` rising edge, which re-enters S_IDLE behaviour on the same edge.
  - S_ERR: entered from any `frame_err`. Sets `uart_error`=1 and `uart_done`=0. No further writes. Leaves only on a new `uart_start` rising edge.
- `uart_start` deasserting during S_RECV/S_WRITE aborts the session:
  - returns to S_IDLE;
  - `uart_done` stays 0;
  - memory already written is not rolled back.
- Session length is fixed: `2^(ROM_DEPTH+1)` words. Instruction half is `[0, 2^ROM_DEPTH-1]`, data half follows.

## Timing
- Reset values:
  - all outputs 0;
  - `uart_data` and `uart_addr` 0;
  - both FSMs idle;
  - the synchroniser flops reset to 1.
- The mid-stop-bit sample of a word's 4th byte is cycle N (synchroniser latency excluded). Then:
  - `byte_valid` in cycle N+1;
  - `uart_write_enable`=1 for exactly cycle N+2, with `uart_data`/`uart_addr` already valid in that cycle.
- `uart_data` and `uart_addr` hold stable from the strobe cycle until the next word's strobe. The address updates on the clock edge ending the strobe cycle.
- `uart_done` rises the cycle after the final strobe.
- `uart_busy` is 1 from the cycle after the start edge through the final strobe cycle.
- Back-to-back bytes (no idle between stop and next start) must be accepted. The receiver is back in RX_IDLE by mid-stop-bit + 1 cycle.
- A `uart_start` rising edge and a `byte_valid` in the same cycle: the start edge wins, and the byte is discarded.
- Async `rst` mid-byte or mid-session:
  - outputs clear immediately;
  - no strobe is issued after release;
  - a new start edge is required.

## Test plan
- **Full upload.** Setup: `CLKS_PER_BIT`=4, `ROM_DEPTH`=2; raise `uart_start`; send 32 bytes 0x00..0x1F. Required:
  - 8 strobes, addresses 0..7;
  - first word 0x03020100, address-4 word 0x13121110;
  - `uart_done`=1 one cycle after the 8th strobe.
- **Framing error.** Send byte 0xA5 with its stop bit driven low. Required:
  - `uart_error`=1, `uart_done`=0;
  - no strobe for that word;
  - a later start edge clears `uart_error`.
- **Start glitch.** Drive `uart_rx` low for 1 cycle (shorter than half a bit). Required: no byte is received, and the next 0x5A byte is assembled correctly.
- **Abort.** Drop `uart_start` after 2 words. Required:
  - the FSM is in S_IDLE;
  - `uart_done`=0;
  - a restarted session begins again at address 0.
- **Async reset.** Assert `rst` mid-byte during word 3. Required: all outputs are 0 in the same cycle, and there are no strobes until the next start edge.
- **Back-to-back stream.** Send the full upload with no idle bits between bytes. Required: identical results to the full-upload case, with strobes spaced 40 bit-times (160 cycles) apart.
